weight_ram_loader: RTL and testbench
====================================

WEIGHT_RAM_LOADER -- requirements
Module: weight_ram_loader

Interface
REQ-001 SHALL have parameter BITWIDTH, 18, width of one weight word.
REQ-002 SHALL have parameter NCOLS, 16, words per RAM row.
REQ-003 SHALL have parameter NROWS, 16, rows per full load.
REQ-004 SHALL have parameter ADDR_WIDTH, 4, RAM row address width; NROWS <= 2**ADDR_WIDTH.
REQ-005 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a full load.
REQ-008 SHALL have port in_data  input  BITWIDTH  weight word stream.
REQ-009 SHALL have port in_valid  input  1  in_data valid.
REQ-010 SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-011 SHALL have port wr_en  output  1  RAM row write strobe.
REQ-012 SHALL have port wr_addr  output  ADDR_WIDTH  RAM row address.
REQ-013 SHALL have port wr_data  output  NCOLS*BITWIDTH  assembled row.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse, load complete.

Function
REQ-016 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-017 IDLE: start=1 -> FILL, row and column counters cleared; other inputs ignored.
REQ-018 FILL: in_ready=1; word accepted only when in_valid&&in_ready; accepted word k of a row stored at wr_data bits [k*BITWIDTH +: BITWIDTH].
REQ-019 FILL: acceptance of word NCOLS-1 -> WRITE next cycle; column counter wraps to 0.
REQ-020 WRITE: exactly one cycle, wr_en=1, wr_addr=current row, wr_data=assembled row, in_ready=0.
REQ-021 WRITE: row NROWS-1 -> DONE; otherwise row counter increments, -> FILL.
REQ-022 DONE: done=1 for one cycle, -> IDLE; in_ready=0.
REQ-023 Latency: last word of a row accepted at cycle n -> wr_en at n+1; done at n+2 for the final row.
REQ-024 busy=1 in FILL, WRITE, DONE; 0 in IDLE.
REQ-025 start while busy SHALL be ignored, no counter effect.
REQ-026 in_valid gaps in FILL SHALL stall without state change; wr_en=0 outside WRITE.
REQ-027 wr_data and wr_addr SHALL hold last written values outside WRITE.

Reset
REQ-028 reset SHALL force IDLE, counters 0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 on the next edge.
REQ-029 reset mid-load SHALL discard the partial row with no write issued; reset overrides start in the same cycle.

Configuration
REQ-030 With WEIGHT_LOADER_CHECKSUM_EN defined, SHALL add output checksum, BITWIDTH+8 bits: modulo-2**(BITWIDTH+8) sum of accepted words, cleared on accepted start and reset, stable from DONE until next start.
REQ-031 Without WEIGHT_LOADER_CHECKSUM_EN, port and adder SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package weight_ram_pkg SHALL hold BITWIDTH, NCOLS, NROWS, ADDR_WIDTH defaults and the state enum, shared with weightRAM.
REQ-033 Row assembly SHALL be one sub-module weight_row_buffer (column-indexed register, write-by-index, clear).

Verification
REQ-034 Full load, words 0..255 continuous -> 16 wr_en pulses, addr 0..15, row r col c = 16r+c, done 2 cycles after word 255 accepted.
REQ-035 in_valid toggling 1/0 -> same 16 rows, no extra or missing wr_en, in_ready=0 on each WRITE cycle.
REQ-036 start pulse at row 5 -> ignored; addresses continue 6..15, single done.
REQ-037 reset after 3 words of row 2 -> IDLE, no wr_en for row 2; new start reloads from addr 0.
REQ-038 CHECKSUM_EN, all words 18'h3FFFF -> checksum 26'h3FFFF00 at done.
REQ-039 NCOLS=4, NROWS=2 -> 2 writes, addr 0 and 1, done after 8 words.

Source files
------------

// File: rtl/weight_ram_pkg.sv
// Shared defaults and loader state encoding for the weight RAM loader and weightRAM.
// Optional feature macro used by the loader: WEIGHT_LOADER_CHECKSUM_EN.
package weight_ram_pkg;

   localparam int WR_BITWIDTH   = 18;
   localparam int WR_NCOLS      = 16;
   localparam int WR_NROWS      = 16;
   localparam int WR_ADDR_WIDTH = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      LS_IDLE  = ST_IDLE,
      LS_FILL  = ST_FILL,
      LS_WRITE = ST_WRITE,
      LS_DONE  = ST_DONE
   } loader_state_e;

   // A single-column row still needs a one-bit column index.
   function automatic int col_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_row_buffer.sv
// Column-indexed row assembly register: one word written per cycle by index,
// whole row cleared on request.
module weight_row_buffer
   import weight_ram_pkg::*;
#(
   parameter  int BITWIDTH = WR_BITWIDTH,
   parameter  int NCOLS    = WR_NCOLS,
   localparam int COL_W    = col_width(NCOLS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [COL_W-1:0]          wr_col,
   input  logic [BITWIDTH-1:0]       wr_word,
   output logic [NCOLS*BITWIDTH-1:0] row
);

   genvar gi;
   generate
      for (gi = 0; gi < NCOLS; gi = gi + 1) begin : g_col
         logic [BITWIDTH-1:0] word_q;
         logic [BITWIDTH-1:0] word_d;

         always_comb begin
            word_d = word_q;
            if (clr) begin
               word_d = '0;
            end else if (wr_en && (wr_col == COL_W'(gi))) begin
               word_d = wr_word;
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign row[gi*BITWIDTH +: BITWIDTH] = word_q;
      end
   endgenerate

endmodule

// File: rtl/weight_ram_loader.sv
// Streams weight words into rows and writes each completed row to the weight RAM.
// Define WEIGHT_LOADER_CHECKSUM_EN to add a running checksum output of accepted words.
module weight_ram_loader
   import weight_ram_pkg::*;
#(
   parameter int BITWIDTH   = WR_BITWIDTH,
   parameter int NCOLS      = WR_NCOLS,
   parameter int NROWS      = WR_NROWS,
   parameter int ADDR_WIDTH = WR_ADDR_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BITWIDTH-1:0]       in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      wr_en,
   output logic [ADDR_WIDTH-1:0]     wr_addr,
   output logic [NCOLS*BITWIDTH-1:0] wr_data,
   output logic                      busy,
   output logic                      done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
   ,
   output logic [BITWIDTH+7:0]       checksum
`endif
);

   localparam int COL_W = col_width(NCOLS);
   localparam int ROW_W = NCOLS * BITWIDTH;

   logic [1:0]            state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ADDR_WIDTH-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
   logic [ROW_W-1:0]      data_hold_q, data_hold_d;
   logic [ROW_W-1:0]      row_word;
   logic                  accept;
   logic                  start_ok;
   logic                  last_col;
   logic                  last_row;

   assign accept   = (state_q == ST_FILL) && in_valid;
   assign start_ok = (state_q == ST_IDLE) && start;
   assign last_col = (col_q == COL_W'(NCOLS - 1));
   assign last_row = (row_q == ADDR_WIDTH'(NROWS - 1));

   weight_row_buffer #(
      .BITWIDTH (BITWIDTH),
      .NCOLS    (NCOLS)
   ) u_row_buffer (
      .clock   (clock),
      .reset   (reset),
      .clr     (start_ok),
      .wr_en   (accept),
      .wr_col  (col_q),
      .wr_word (in_data),
      .row     (row_word)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      addr_hold_d = addr_hold_q;
      data_hold_d = data_hold_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         ST_FILL: begin
            if (accept) begin
               if (last_col) begin
                  col_d   = '0;
                  state_d = ST_WRITE;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         ST_WRITE: begin
            // Capture what is being written so the RAM-side outputs hold afterwards.
            addr_hold_d = row_q;
            data_hold_d = row_word;
            if (last_row) begin
               state_d = ST_DONE;
            end else begin
               row_d   = row_q + ADDR_WIDTH'(1);
               state_d = ST_FILL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         addr_hold_q <= '0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         addr_hold_q <= addr_hold_d;
         data_hold_q <= data_hold_d;
      end
   end

   assign in_ready = (state_q == ST_FILL);
   assign wr_en    = (state_q == ST_WRITE);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign wr_addr  = wr_en ? row_q : addr_hold_q;
   assign wr_data  = wr_en ? row_word : data_hold_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [BITWIDTH+7:0] checksum_q, checksum_d;

   // Wraps naturally at the register width.
   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (accept) begin
         checksum_d = checksum_q + {8'd0, in_data};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_ram_loader.sv
// Scoreboard bench for weight_ram_loader: driver queues expected rows, monitor checks
// every write, done pulse, hold behaviour and latency against a simple row model.
module tb_weight_ram_loader;

   localparam int BW  = 18;
   localparam int NC  = 16;
   localparam int NR  = 16;
   localparam int AW  = 4;
   localparam int RW  = NC * BW;
   localparam int CSW = BW + 8;
   localparam int SNC = 4;
   localparam int SNR = 2;
   localparam int SRW = SNC * BW;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [RW-1:0] wr_data;
   logic          busy;
   logic          done;

   logic           s_start;
   logic [BW-1:0]  s_in_data;
   logic           s_in_valid;
   logic           s_in_ready;
   logic           s_wr_en;
   logic [AW-1:0]  s_wr_addr;
   logic [SRW-1:0] s_wr_data;
   logic           s_busy;
   logic           s_done;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [CSW-1:0] checksum;
   logic [CSW-1:0] s_checksum;
`endif

   weight_ram_loader #(
      .BITWIDTH(BW), .NCOLS(NC), .NROWS(NR), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   weight_ram_loader #(
      .BITWIDTH(BW), .NCOLS(SNC), .NROWS(SNR), .ADDR_WIDTH(AW)
   ) u_small (
      .clock(clock), .reset(reset), .start(s_start), .in_data(s_in_data),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .busy(s_busy), .done(s_done)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      , .checksum(s_checksum)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [RW-1:0] data;
   } row_t;

   row_t           exp_q[$];
   int             done_exp  = 0;
   int             done_seen = 0;
   int             last_acc  = 0;
   logic [CSW-1:0] exp_sum   = '0;
   logic [AW-1:0]  hold_addr = '0;
   logic [RW-1:0]  hold_data = '0;
   bit             mon_en    = 1'b0;

   logic [SRW-1:0] s_q[$];
   int             s_writes    = 0;
   int             s_done_seen = 0;
   int             s_last      = 0;
   int             s_addr_exp  = 0;

   // Main-instance monitor
   always @(negedge clock) begin
      row_t r;
      if (mon_en) begin
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_wr_en", 1, 0);
            end else begin
               r = exp_q.pop_front();
               chk("wr_addr", wr_addr, r.addr);
               chk("wr_data", wr_data, r.data);
               chk("wr_latency", cyc, last_acc + 1);
               chk("in_ready_in_write", in_ready, 0);
               chk("busy_in_write", busy, 1);
               $display("write addr=%0d data=%0h cycle=%0d", wr_addr, wr_data, cyc);
               hold_addr = r.addr;
               hold_data = r.data;
            end
         end else begin
            chk("wr_addr_hold", wr_addr, hold_addr);
            chk("wr_data_hold", wr_data, hold_data);
         end
         if (done) begin
            if (done_exp == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               done_exp--;
               chk("done_latency", cyc, last_acc + 2);
               chk("in_ready_in_done", in_ready, 0);
               chk("rows_outstanding_at_done", exp_q.size(), 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
               chk("checksum", checksum, exp_sum);
`endif
            end
            $display("done cycle=%0d", cyc);
            done_seen++;
         end
      end
   end

   // Small-instance monitor
   always @(negedge clock) begin
      logic [SRW-1:0] sr;
      if (mon_en) begin
         if (s_wr_en) begin
            if (s_q.size() == 0) begin
               chk("small_unexpected_wr_en", 1, 0);
            end else begin
               sr = s_q.pop_front();
               chk("small_wr_addr", s_wr_addr, s_addr_exp);
               chk("small_wr_data", s_wr_data, sr);
               $display("small write addr=%0d data=%0h", s_wr_addr, s_wr_data);
               s_addr_exp++;
            end
            s_writes++;
         end
         if (s_done) begin
            chk("small_writes_at_done", s_writes, SNR);
            chk("small_done_latency", cyc, s_last + 2);
            $display("small done cycle=%0d", cyc);
            s_done_seen++;
         end
      end
   end

   // mode: 0 sequential/continuous, 1 toggling valid, 2 random gaps, 3 all ones
   task automatic do_load(input int mode, input int start_at, input int reset_at);
      logic [BW-1:0] words[NC*NR];
      row_t          r;
      int            nrows;
      int            idx;
      int            guard;
      int            ds0;
      bit            injected;
      for (int i = 0; i < NC*NR; i++) begin
         case (mode)
            0:       words[i] = BW'(i);
            3:       words[i] = '1;
            default: words[i] = BW'($urandom);
         endcase
      end
      nrows = (reset_at < 0) ? NR : reset_at / NC;
      for (int rr = 0; rr < nrows; rr++) begin
         r.addr = AW'(rr);
         r.data = '0;
         for (int c = 0; c < NC; c++) r.data[c*BW +: BW] = words[rr*NC + c];
         exp_q.push_back(r);
      end
      if (reset_at < 0) done_exp++;
      ds0 = done_seen;

      start = 1'b1;
      @(posedge clock); #1;
      start   = 1'b0;
      exp_sum = '0;
      @(negedge clock);
      chk("busy_after_start", busy, 1);
      @(posedge clock); #1;

      idx = 0; guard = 0; injected = 1'b0;
      while (idx < NC*NR && guard < 4000) begin
         if (reset_at >= 0 && idx == reset_at) break;
         if (start_at >= 0 && idx == start_at && !injected) begin
            start    = 1'b1;
            injected = 1'b1;
         end
         case (mode)
            1:       in_valid = (guard % 2 == 0);
            2:       in_valid = ($urandom_range(0, 3) != 0);
            default: in_valid = 1'b1;
         endcase
         in_data = words[idx];
         @(negedge clock);
         if (in_valid && in_ready) begin
            last_acc = cyc;
            exp_sum  = exp_sum + {8'd0, in_data};
            idx++;
         end
         @(posedge clock); #1;
         start = 1'b0;
         guard++;
      end
      in_valid = 1'b0;
      if (guard >= 4000) chk("load_timeout", idx, NC*NR);

      if (reset_at >= 0) begin
         reset = 1'b1;
         @(posedge clock); #1;
         reset     = 1'b0;
         hold_addr = '0;
         hold_data = '0;
         exp_sum   = '0;
         @(negedge clock);
         chk("reset_busy", busy, 0);
         chk("reset_in_ready", in_ready, 0);
         chk("reset_done", done, 0);
         chk("reset_wr_addr", wr_addr, 0);
         chk("reset_wr_data", wr_data, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
         chk("reset_checksum", checksum, 0);
`endif
         @(posedge clock); #1;
      end else begin
         guard = 0;
         while (done_seen == ds0 && guard < 20) begin
            @(posedge clock); #1;
            guard++;
         end
         chk("done_seen", done_seen, ds0 + 1);
         @(negedge clock);
         chk("busy_after_done", busy, 0);
         @(posedge clock); #1;
      end
      $display("load mode=%0d start_at=%0d reset_at=%0d finished cycle=%0d", mode, start_at, reset_at, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0]  sw[SNC*SNR];
      logic [SRW-1:0] srow;
      int             sidx;
      int             guard;

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      chk("rst_checksum", checksum, 0);
`endif
      @(posedge clock); #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Words offered without start are ignored
      in_valid = 1'b1;
      in_data  = BW'($urandom);
      repeat (3) begin
         @(negedge clock);
         chk("idle_in_ready", in_ready, 0);
         chk("idle_busy", busy, 0);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;

      do_load(0, -1, -1);
      do_load(1, -1, -1);
      do_load(2, 82, -1);
      do_load(2, -1, 35);
      do_load(0, -1, -1);

      // Reset wins over a simultaneous start
      reset = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; start = 1'b0;
      hold_addr = '0;
      hold_data = '0;
      @(negedge clock);
      chk("reset_over_start_busy", busy, 0);
      @(posedge clock); #1;

      do_load(3, -1, -1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      chk("checksum_all_ones", checksum, 26'h3FFFF00);
`endif

      // Small geometry: 4 columns x 2 rows
      for (int i = 0; i < SNC*SNR; i++) sw[i] = BW'($urandom);
      for (int rr = 0; rr < SNR; rr++) begin
         srow = '0;
         for (int c = 0; c < SNC; c++) srow[c*BW +: BW] = sw[rr*SNC + c];
         s_q.push_back(srow);
      end
      s_start = 1'b1;
      @(posedge clock); #1;
      s_start = 1'b0;
      sidx = 0; guard = 0;
      while (sidx < SNC*SNR && guard < 100) begin
         s_in_valid = 1'b1;
         s_in_data  = sw[sidx];
         @(negedge clock);
         if (s_in_valid && s_in_ready) begin
            s_last = cyc;
            sidx++;
         end
         @(posedge clock); #1;
         guard++;
      end
      s_in_valid = 1'b0;
      chk("small_words_accepted", sidx, SNC*SNR);
      guard = 0;
      while (s_done_seen == 0 && guard < 20) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("small_done_seen", s_done_seen, 1);
      repeat (3) @(posedge clock);
      #1;

      chk("pending_rows", exp_q.size(), 0);
      chk("pending_done", done_exp, 0);
      chk("small_pending_rows", s_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
